// File: rtl/exp_controller_if.sv
// -----------------------------------------------------------------------------
// exp_controller_if
//   Bundles the control and handshake signals of exp_controller: the start
//   level, the datapath status flags, the datapath mux selects and load
//   strobes, the LCD req/ack handshake and the run status outputs.
//
//   modport master : controller side (drives selects, strobes, status, lcd_req)
//   modport slave  : datapath / LCD / top-level side (drives start, flags, ack)
//
//   Signals
//     start          top-level start level
//     n_grtr_0       datapath n register is nonzero
//     n_lsb          bit 0 of datapath n register
//     lcd_ack        LCD controller accepted the result
//     sel_a_reg      0 = load a_i, 1 = load a*a
//     sel_n_reg      0 = load n_i, 1 = load n>>1
//     sel_result_reg 0 = load 1,   1 = load result*a
//     ld_a, ld_n, ld_result, ld_output   datapath load strobes
//     lcd_req        result valid for the LCD, held until ack
//     busy           controller is not idle
//     done           one-cycle pulse on handshake completion
//     err            one-cycle pulse on abort
//     iter_cnt       LOOP update steps taken in the current run
// -----------------------------------------------------------------------------
interface exp_controller_if;
    logic       start;
    logic       n_grtr_0;
    logic       n_lsb;
    logic       lcd_ack;
    logic       sel_a_reg;
    logic       sel_n_reg;
    logic       sel_result_reg;
    logic       ld_a;
    logic       ld_n;
    logic       ld_result;
    logic       ld_output;
    logic       lcd_req;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] iter_cnt;

    modport master (
        input  start, n_grtr_0, n_lsb, lcd_ack,
        output sel_a_reg, sel_n_reg, sel_result_reg,
        output ld_a, ld_n, ld_result, ld_output,
        output lcd_req, busy, done, err, iter_cnt
    );

    modport slave (
        output start, n_grtr_0, n_lsb, lcd_ack,
        input  sel_a_reg, sel_n_reg, sel_result_reg,
        input  ld_a, ld_n, ld_result, ld_output,
        input  lcd_req, busy, done, err, iter_cnt
    );
endinterface

// File: rtl/exp_controller.sv
// -----------------------------------------------------------------------------
// exp_controller
//   Sequences a square-and-multiply exponent datapath to compute a^n, then
//   hands the result to the LCD controller over a req/ack handshake.
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : exp_controller_if.master (datapath controls, flags, LCD handshake)
//
//   Parameters
//     ITER_LIMIT  : LOOP update steps allowed before the run aborts (n width)
//     ACK_TIMEOUT : REPORT cycles without lcd_ack before timing out
//
//   Build option
//     LCD_TIMEOUT_EN : when defined, REPORT gives up after ACK_TIMEOUT cycles
//                      without lcd_ack, pulsing err. When undefined, REPORT
//                      waits for lcd_ack indefinitely.
//
//   All strobes and selects are combinational decodes of state and the
//   datapath flags; the datapath registers them on the next edge.
// -----------------------------------------------------------------------------
module exp_controller #(
    parameter int unsigned ITER_LIMIT  = 8,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    exp_controller_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LOOP   = 3'd2,
        WRITE  = 3'd3,
        REPORT = 3'd4
    } state_t;

    // Elaboration-time parameter sanity checks.
    if (ITER_LIMIT < 1 || ITER_LIMIT > 15) begin : g_bad_iter_limit
        $error("ITER_LIMIT must fit the 4-bit iter_cnt");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    state_t     state_q, state_d;
    logic [3:0] iter_cnt_q, iter_cnt_d;

`ifdef LCD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // NOTE: combinational logic uses blocking '=' and gives every output a
    // default first, so no path through the case statement infers a latch.
    always_comb begin
        state_d            = state_q;
        iter_cnt_d         = iter_cnt_q;
        bus.sel_a_reg      = 1'b0;
        bus.sel_n_reg      = 1'b0;
        bus.sel_result_reg = 1'b0;
        bus.ld_a           = 1'b0;
        bus.ld_n           = 1'b0;
        bus.ld_result      = 1'b0;
        bus.ld_output      = 1'b0;
        bus.lcd_req        = 1'b0;
        bus.done           = 1'b0;
        bus.err            = 1'b0;
        bus.busy           = (state_q != IDLE);
`ifdef LCD_TIMEOUT_EN
        tmo_cnt_d          = tmo_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = LOAD;
                    iter_cnt_d = 4'd0;
                end
            end

            LOAD: begin
                // All selects stay 0: a = a_i, n = n_i, result = 1.
                bus.ld_a      = 1'b1;
                bus.ld_n      = 1'b1;
                bus.ld_result = 1'b1;
                state_d       = LOOP;
            end

            LOOP: begin
                if (bus.n_grtr_0) begin
                    if (iter_cnt_q == 4'(ITER_LIMIT)) begin
                        // n failed to reach zero within its own bit width.
                        bus.err = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bus.ld_a      = 1'b1;
                        bus.sel_a_reg = 1'b1;
                        bus.ld_n      = 1'b1;
                        bus.sel_n_reg = 1'b1;
                        // result*a is formed from the pre-square a because
                        // both registers update on the same edge.
                        if (bus.n_lsb) begin
                            bus.ld_result      = 1'b1;
                            bus.sel_result_reg = 1'b1;
                        end
                        iter_cnt_d = iter_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = WRITE;
                end
            end

            WRITE: begin
                bus.ld_output = 1'b1;
                state_d       = REPORT;
`ifdef LCD_TIMEOUT_EN
                tmo_cnt_d     = '0;
`endif
            end

            REPORT: begin
                bus.lcd_req = 1'b1;
                if (bus.lcd_ack) begin
                    bus.done = 1'b1;
                    state_d  = IDLE;
                end
`ifdef LCD_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT)) begin
                    // Give up on the LCD; the output register keeps its value.
                    bus.err = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.iter_cnt = iter_cnt_q;

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            iter_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

`ifdef LCD_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_exp_controller.sv
// -----------------------------------------------------------------------------
// tb_exp_controller
//   Directed bench for exp_controller. A small square-and-multiply datapath
//   (16-bit a/result/output, 8-bit n, reset by rst) is built around the
//   controller. Expected outputs and latencies are hand-computed constants.
//   Cycle 0 is the cycle in which start is sampled high in IDLE.
// -----------------------------------------------------------------------------
module tb_exp_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exp_controller_if bus ();

`ifdef LCD_TIMEOUT_EN
    exp_controller #(.ITER_LIMIT(8), .ACK_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );
`else
    exp_controller #(.ITER_LIMIT(8), .ACK_TIMEOUT(1023)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );
`endif

    // ---------------- datapath ----------------
    logic [15:0] a_i;
    logic [7:0]  n_i;
    logic        stuck_n;    // freezes n to provoke the iteration abort
    logic [15:0] a_q, result_q, out_q;
    logic [7:0]  n_q;
    logic        rst_n;

    assign rst_n        = ~rst;
    assign bus.n_grtr_0 = (n_q != 8'd0);
    assign bus.n_lsb    = n_q[0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= 16'd0;
            n_q      <= 8'd0;
            result_q <= 16'd0;
            out_q    <= 16'd0;
        end else begin
            if (bus.ld_a)      a_q      <= bus.sel_a_reg ? 16'(a_q * a_q) : a_i;
            if (bus.ld_n && !(stuck_n && bus.sel_n_reg))
                               n_q      <= bus.sel_n_reg ? (n_q >> 1) : n_i;
            if (bus.ld_result) result_q <= bus.sel_result_reg ? 16'(result_q * a_q) : 16'd1;
            if (bus.ld_output) out_q    <= result_q;
        end
    end

    // ---------------- pulse counters ----------------
    int done_cnt = 0;
    int err_cnt  = 0;
    always @(posedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.err)  err_cnt++;
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle; returns at the negedge of cycle 1.
    task automatic start_run(input int a, input int n);
        @(negedge clk);
        a_i       = 16'(a);
        n_i       = 8'(n);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Starting at cycle 1, waits until lcd_req is high; returns its cycle.
    task automatic wait_req(output int cyc);
        cyc = 1;
        while (!bus.lcd_req && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int d0;
    int e0;
    int low_cnt;

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.lcd_ack = 1'b0;
        a_i         = 16'd0;
        n_i         = 8'd0;
        stuck_n     = 1'b0;
        #12;
        check("reset_busy",     int'(bus.busy),     0);
        check("reset_lcd_req",  int'(bus.lcd_req),  0);
        check("reset_strobes",  int'({bus.ld_a, bus.ld_n, bus.ld_result, bus.ld_output}), 0);
        check("reset_iter_cnt", int'(bus.iter_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- 3^5, ack two cycles after lcd_req ----
        d0 = done_cnt;
        start_run(3, 5);
        wait_req(cyc);
        check("p35_req_cycle", cyc, 7);
        @(negedge clk);
        check("p35_req_held", int'(bus.lcd_req), 1);
        @(negedge clk);
        bus.lcd_ack = 1'b1;
        #1;
        check("p35_done_with_ack", int'(bus.done), 1);
        check("p35_busy_at_done",  int'(bus.busy), 1);
        @(negedge clk);
        bus.lcd_ack = 1'b0;
        #1;
        check("p35_busy_after",  int'(bus.busy),    0);
        check("p35_req_after",   int'(bus.lcd_req), 0);
        check("p35_output",      int'(out_q),       243);
        check("p35_iter_cnt",    int'(bus.iter_cnt), 3);
        check("p35_done_once",   done_cnt - d0,     1);

        // ---- 7^0 ----
        start_run(7, 0);
        wait_req(cyc);
        check("p70_req_cycle", cyc, 4);
        bus.lcd_ack = 1'b1;
        @(negedge clk);
        bus.lcd_ack = 1'b0;
        check("p70_output",   int'(out_q),        1);
        check("p70_iter_cnt", int'(bus.iter_cnt), 0);

        // ---- 2^8 with a second start during LOOP ----
        d0 = done_cnt;
        start_run(2, 8);
        @(negedge clk);                 // cycle 2, LOOP
        bus.start = 1'b1;
        @(negedge clk);                 // cycle 3
        bus.start = 1'b0;
        check("p28_busy_in_loop", int'(bus.busy), 1);
        wait_req(cyc);
        check("p28_req_cycle", cyc + 2, 8);
        bus.lcd_ack = 1'b1;
        @(negedge clk);
        bus.lcd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("p28_output",      int'(out_q),    256);
        check("p28_done_once",   done_cnt - d0,  1);
        check("p28_idle_after",  int'(bus.busy), 0);

`ifndef LCD_TIMEOUT_EN
        // ---- 2^3 with lcd_ack held low for 500 cycles ----
        d0 = done_cnt;
        start_run(2, 3);
        wait_req(cyc);
        check("p23_req_cycle", cyc, 6);
        low_cnt = 0;
        repeat (500) begin
            if (!bus.lcd_req) low_cnt++;
            @(negedge clk);
        end
        check("p23_req_never_low", low_cnt, 0);
        check("p23_no_early_done", done_cnt - d0, 0);
        bus.lcd_ack = 1'b1;
        #1;
        check("p23_done_with_ack", int'(bus.done), 1);
        @(negedge clk);
        bus.lcd_ack = 1'b0;
        check("p23_output", int'(out_q), 8);
`endif

        // ---- reset mid-LOOP, then 5^6 ----
        d0 = done_cnt;
        start_run(5, 6);
        @(negedge clk);                 // cycle 2, LOOP
        @(negedge clk);                 // cycle 3, LOOP
        rst = 1'b1;
        #1;
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_outputs", int'({bus.ld_a, bus.ld_n, bus.ld_result, bus.ld_output,
                                   bus.sel_a_reg, bus.sel_n_reg, bus.sel_result_reg,
                                   bus.lcd_req, bus.done, bus.err}), 0);
        check("rst_iter_cnt", int'(bus.iter_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_no_done", done_cnt - d0, 0);
        start_run(5, 6);
        wait_req(cyc);
        check("p56_req_cycle", cyc, 7);
        bus.lcd_ack = 1'b1;
        @(negedge clk);
        bus.lcd_ack = 1'b0;
        check("p56_output",   int'(out_q),        15625);
        check("p56_iter_cnt", int'(bus.iter_cnt), 3);
        check("p56_done_once", done_cnt - d0,     1);

        // ---- iteration abort: n frozen so it never reaches zero ----
        d0 = done_cnt;
        e0 = err_cnt;
        stuck_n = 1'b1;
        start_run(3, 5);
        cyc = 1;
        while (!bus.err && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_err_cycle", cyc, 10);
        check("abort_iter_cnt",  int'(bus.iter_cnt), 8);
        @(negedge clk);
        stuck_n = 1'b0;
        check("abort_idle",      int'(bus.busy),  0);
        check("abort_err_once",  err_cnt - e0,    1);
        check("abort_no_done",   done_cnt - d0,   0);
        check("abort_no_write",  int'(out_q),     15625);

`ifdef LCD_TIMEOUT_EN
        // ---- ack never arrives: time out after 16 cycles ----
        d0 = done_cnt;
        e0 = err_cnt;
        start_run(2, 3);
        wait_req(cyc);
        check("tmo_req_cycle", cyc, 6);
        repeat (15) @(negedge clk);
        check("tmo_no_err_early", int'(bus.err), 0);
        @(negedge clk);
        check("tmo_err_pulse", int'(bus.err), 1);
        @(negedge clk);
        check("tmo_req_dropped", int'(bus.lcd_req), 0);
        check("tmo_idle",        int'(bus.busy),    0);
        check("tmo_err_once",    err_cnt - e0,      1);
        check("tmo_no_done",     done_cnt - d0,     0);
        check("tmo_output_kept", int'(out_q),       8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
